// File: rtl/rx_channel_scheduler_pkg.sv
// Shared types and helpers for the RX channel scheduler: FSM states, channel ids,
// SMI byte-beat payload and the grant rule.
package rx_channel_scheduler_pkg;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned N_CH      = 2;
    localparam int unsigned BYTE_IDX_W = 2;

    localparam logic CH_09 = 1'b0;
    localparam logic CH_24 = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PULL = 2'd1,
        ST_WAIT = 2'd2,
        ST_SEND = 2'd3
    } sched_state_t;

    typedef struct packed {
        logic              ch;
        logic              word_start;
        logic [BYTE_W-1:0] data;
    } smi_beat_t;

    // Priority mode favours CH_09; round-robin prefers the channel not served last.
    function automatic logic pick_grant(input logic [N_CH-1:0] elig,
                                        input logic            prio_09,
                                        input logic            last_grant);
        if (prio_09) begin
            return elig[CH_09] ? CH_09 : CH_24;
        end
        return elig[~last_grant] ? ~last_grant : last_grant;
    endfunction

endpackage

// File: rtl/rx_channel_scheduler_if.sv
// Byte stream towards smi_ctrl: valid/ready handshake carrying one tagged byte per beat.
interface rx_channel_scheduler_if;
    logic                                   valid;
    logic                                   ready;
    rx_channel_scheduler_pkg::smi_beat_t    beat;

    modport master (output valid, output beat, input  ready);
    modport slave  (input  valid, input  beat, output ready);
endinterface

// File: rtl/rx_channel_scheduler_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             i_sys_clk,
    input  logic             i_reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge i_sys_clk) begin
        if (i_reset || clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/rx_channel_scheduler.sv
// Arbitrates the two RX sample FIFOs onto the byte-wide SMI read path, serialising
// each 32-bit I/Q word MSB first and counting FIFO-full cycles per channel.
module rx_channel_scheduler
    import rx_channel_scheduler_pkg::*;
#(
    parameter int unsigned BURST_WORDS = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                    i_sys_clk,
    input  logic                    i_reset,
    input  logic [N_CH-1:0]         i_ch_enable,
    input  logic                    i_prio_09,
    input  logic                    i_clr_stats,
    output logic                    o_fifo_09_pull,
    input  logic [WORD_W-1:0]       i_fifo_09_data,
    input  logic                    i_fifo_09_empty,
    input  logic                    i_fifo_09_full,
    output logic                    o_fifo_24_pull,
    input  logic [WORD_W-1:0]       i_fifo_24_data,
    input  logic                    i_fifo_24_empty,
    input  logic                    i_fifo_24_full,
    rx_channel_scheduler_if.master  smi,
    output logic                    o_busy,
    output logic [CNT_W-1:0]        o_ovf_cnt_09,
    output logic [CNT_W-1:0]        o_ovf_cnt_24
);

    localparam int unsigned BC_W = (BURST_WORDS > 1) ? $clog2(BURST_WORDS) : 1;

    sched_state_t          state;
    logic                  grant;
    logic                  last_grant;
    logic [BC_W-1:0]       burst_cnt;
    logic [BYTE_IDX_W-1:0] byte_idx;
    logic [WORD_W-1:0]     shift_reg;

    logic [N_CH-1:0]       elig;
    logic                  next_grant;
    logic [WORD_W-1:0]     sel_data;
    logic                  burst_done;

    always_comb begin
        elig       = i_ch_enable & {~i_fifo_24_empty, ~i_fifo_09_empty};
        next_grant = pick_grant(elig, i_prio_09, last_grant);
        sel_data   = (grant == CH_24) ? i_fifo_24_data : i_fifo_09_data;
        burst_done = (burst_cnt == BC_W'(BURST_WORDS - 1)) || !elig[grant];
    end

    // Arbiter, FSM and serializer; every output is a register written here.
    always_ff @(posedge i_sys_clk) begin
        if (i_reset) begin
            state          <= ST_IDLE;
            grant          <= CH_09;
            last_grant     <= CH_24;
            burst_cnt      <= '0;
            byte_idx       <= '0;
            shift_reg      <= '0;
            o_fifo_09_pull <= 1'b0;
            o_fifo_24_pull <= 1'b0;
            o_busy         <= 1'b0;
            smi.valid      <= 1'b0;
            smi.beat       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|elig) begin
                        grant          <= next_grant;
                        o_fifo_09_pull <= (next_grant == CH_09);
                        o_fifo_24_pull <= (next_grant == CH_24);
                        o_busy         <= 1'b1;
                        state          <= ST_PULL;
                    end
                end
                ST_PULL: begin
                    o_fifo_09_pull <= 1'b0;
                    o_fifo_24_pull <= 1'b0;
                    state          <= ST_WAIT;
                end
                ST_WAIT: begin
                    shift_reg           <= sel_data;
                    byte_idx            <= '0;
                    smi.valid           <= 1'b1;
                    smi.beat.ch         <= grant;
                    smi.beat.word_start <= 1'b1;
                    smi.beat.data       <= sel_data[WORD_W-1 -: BYTE_W];
                    state               <= ST_SEND;
                end
                ST_SEND: begin
                    if (smi.ready) begin
                        smi.beat.word_start <= 1'b0;
                        if (byte_idx == BYTE_IDX_W'(3)) begin
                            smi.valid <= 1'b0;
                            // A disabled or drained channel ends the burst early.
                            if (burst_done) begin
                                last_grant <= grant;
                                burst_cnt  <= '0;
                                o_busy     <= 1'b0;
                                state      <= ST_IDLE;
                            end else begin
                                burst_cnt      <= burst_cnt + BC_W'(1);
                                o_fifo_09_pull <= (grant == CH_09);
                                o_fifo_24_pull <= (grant == CH_24);
                                state          <= ST_PULL;
                            end
                        end else begin
                            shift_reg     <= shift_reg << BYTE_W;
                            smi.beat.data <= shift_reg[WORD_W-BYTE_W-1 -: BYTE_W];
                            byte_idx      <= byte_idx + BYTE_IDX_W'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_ovf_09 (
        .i_sys_clk (i_sys_clk),
        .i_reset   (i_reset),
        .inc       (i_ch_enable[CH_09] & i_fifo_09_full),
        .clr       (i_clr_stats),
        .count     (o_ovf_cnt_09)
    );

    sat_counter #(.WIDTH(CNT_W)) u_ovf_24 (
        .i_sys_clk (i_sys_clk),
        .i_reset   (i_reset),
        .inc       (i_ch_enable[CH_24] & i_fifo_24_full),
        .clr       (i_clr_stats),
        .count     (o_ovf_cnt_24)
    );

endmodule
